// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: transfer-size encodings, region decode
// constants and MMIO register offsets.
package dmem_pkg;

    typedef enum logic [2:0] {
        MemB  = 3'b000,
        MemH  = 3'b001,
        MemW  = 3'b010,
        MemBu = 3'b100,
        MemHu = 3'b101
    } mem_type_e;

    // RAM occupies the bottom 256 MiB of the address space.
    localparam logic [3:0] RamRegion = 4'h0;

    localparam logic [31:0] MmioGpioOff   = 32'h0000_0000;
    localparam logic [31:0] MmioCountOff  = 32'h0000_0004;
    localparam logic [31:0] MmioStatusOff = 32'h0000_0008;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: byte enables, store-data shift, load-data
// extraction (zero-extended) and misalignment detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_type,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data_sh,
    output logic [31:0] rd_data,
    output logic        misaligned
);

    logic [31:0] rd_shifted;

    always_comb begin
        byte_en    = 4'b0000;
        misaligned = 1'b1;
        rd_data    = '0;
        rd_shifted = rd_word >> {addr_lo, 3'b000};
        wr_data_sh = wr_data << {addr_lo, 3'b000};
        case (mem_type)
            MemB, MemBu: begin
                byte_en    = 4'b0001 << addr_lo;
                misaligned = 1'b0;
                rd_data    = {24'b0, rd_shifted[7:0]};
            end
            MemH, MemHu: begin
                byte_en    = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                rd_data    = {16'b0, rd_shifted[15:0]};
            end
            MemW: begin
                byte_en    = 4'b1111;
                misaligned = (addr_lo != 2'b00);
                rd_data    = rd_word;
            end
            default: ; // reserved encodings stay misaligned
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Data memory unit: byte-addressable RAM with zero-latency loads and a sticky misalignment
// flag. Defining DATA_MEM_MMIO_EN adds GPIO, cycle-counter and status registers at MMIO_BASE.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic        misalign_err,
    output logic [15:0] gpio_out
);

    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AddrW-1:0] word_idx;
    logic             ram_hit;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data_sh;
    logic [31:0]      lane_rd_data;
    logic             lane_mis;
    logic             ram_wr;

    logic             mmio_hit;
    logic             mmio_mis;
    logic [31:0]      mmio_rd_data;
    logic             status_clr;

    logic             err_set;
    logic             misalign_err_q;
    logic             misalign_err_d;
    logic             unused_addr;

    assign word_idx    = MEM_addr[AddrW+1:2];
    assign ram_hit     = (MEM_addr[31:28] == RamRegion);
    assign unused_addr = ^MEM_addr;

    dmem_lane_align u_lane_align (
        .addr_lo    (MEM_addr[1:0]),
        .mem_type   (MEM_type),
        .wr_data    (MEM_WR_out),
        .rd_word    (mem[word_idx]),
        .byte_en    (byte_en),
        .wr_data_sh (wr_data_sh),
        .rd_data    (lane_rd_data),
        .misaligned (lane_mis)
    );

    assign ram_wr = MEM_wr_en & ram_hit & ~lane_mis;

    // Contents are never cleared; Reset only blocks a store landing on an edge while low.
    always_ff @(posedge CLK or negedge Reset) begin
        if (Reset && ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data_sh[8*b +: 8];
                end
            end
        end
    end

`ifdef DATA_MEM_MMIO_EN
    logic        gpio_hit;
    logic        count_hit;
    logic        status_hit;
    logic        mmio_wr;
    logic [15:0] gpio_q;
    logic [15:0] gpio_d;
    logic [31:0] count_q;

    assign gpio_hit   = ({MEM_addr[31:2], 2'b00} == MMIO_BASE + MmioGpioOff);
    assign count_hit  = ({MEM_addr[31:2], 2'b00} == MMIO_BASE + MmioCountOff);
    assign status_hit = ({MEM_addr[31:2], 2'b00} == MMIO_BASE + MmioStatusOff);
    assign mmio_hit   = gpio_hit | count_hit | status_hit;
    assign mmio_mis   = lane_mis | (MEM_type != MemW);
    assign mmio_wr    = MEM_wr_en & mmio_hit & ~mmio_mis;
    assign status_clr = mmio_wr & status_hit & MEM_WR_out[0];
    assign gpio_d     = (mmio_wr && gpio_hit) ? MEM_WR_out[15:0] : gpio_q;

    always_comb begin
        mmio_rd_data = '0;
        if (gpio_hit) begin
            mmio_rd_data = {16'b0, gpio_q};
        end else if (count_hit) begin
            mmio_rd_data = count_q;
        end else if (status_hit) begin
            mmio_rd_data = {31'b0, misalign_err_q};
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            gpio_q  <= '0;
            count_q <= '0;
        end else begin
            gpio_q  <= gpio_d;
            count_q <= count_q + 32'd1;
        end
    end

    assign gpio_out = gpio_q;
`else
    logic unused_cfg;

    assign mmio_hit     = 1'b0;
    assign mmio_mis     = 1'b0;
    assign mmio_rd_data = '0;
    assign status_clr   = 1'b0;
    assign gpio_out     = '0;
    assign unused_cfg   = ^MMIO_BASE;
`endif

    // Simultaneous load+store is itself an error, whatever the region.
    assign err_set = (MEM_rd_en & MEM_wr_en) |
                     ((MEM_rd_en | MEM_wr_en) & ((ram_hit & lane_mis) | (mmio_hit & mmio_mis)));
    assign misalign_err_d = err_set | (misalign_err_q & ~status_clr);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end

    assign misalign_err = misalign_err_q;

    always_comb begin
        MEM_data = '0;
        if (MEM_rd_en && !MEM_wr_en) begin
            if (ram_hit && !lane_mis) begin
                MEM_data = lane_rd_data;
            end else if (mmio_hit && !mmio_mis) begin
                MEM_data = mmio_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: stimulus pushes expected outputs from a byte-array
// reference model, a negedge monitor pops and compares. Honours DATA_MEM_MMIO_EN.
module tb_data_mem_unit;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Bytes = Depth * 4;
    localparam logic [31:0] Base  = 32'h8000_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en;
    logic        MEM_wr_en;
    logic [31:0] MEM_data;
    logic        misalign_err;
    logic [15:0] gpio_out;

    always #5 CLK = ~CLK;

    data_mem_unit #(
        .DEPTH_WORDS (Depth),
        .MMIO_BASE   (Base)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .MEM_addr     (MEM_addr),
        .MEM_WR_out   (MEM_WR_out),
        .MEM_type     (MEM_type),
        .MEM_rd_en    (MEM_rd_en),
        .MEM_wr_en    (MEM_wr_en),
        .MEM_data     (MEM_data),
        .misalign_err (misalign_err),
        .gpio_out     (gpio_out)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [15:0] gpio;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;

    byte unsigned model_mem [Bytes];
    logic         model_err;
    logic [15:0]  model_gpio;
    logic [31:0]  model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, " data"}, MEM_data, mon_e.data);
            check({mon_e.name, " err"}, {31'b0, misalign_err}, {31'b0, mon_e.err});
            check({mon_e.name, " gpio"}, {16'b0, gpio_out}, {16'b0, mon_e.gpio});
        end
    end

    // Region kinds: 0 unmapped, 1 RAM, 2 GPIO, 3 counter, 4 status.
    function automatic int region_of(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (a < 32'h1000_0000) return 1;
`ifdef DATA_MEM_MMIO_EN
        if (w == Base)      return 2;
        if (w == Base + 4)  return 3;
        if (w == Base + 8)  return 4;
`endif
        return 0;
    endfunction

    task automatic cycle(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d, input string name);
        int   sz;
        int   kind;
        bit   bad;
        bit   set;
        bit   clr;
        exp_t e;
        MEM_rd_en  = rd;
        MEM_wr_en  = wr;
        MEM_type   = t;
        MEM_addr   = a;
        MEM_WR_out = d;
        case (t)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        bad = (sz == 0);
        if (!bad) bad = (a % sz) != 0;
        kind = region_of(a);
        if (kind >= 2 && t != 3'd2) bad = 1'b1;
        e.data = 32'h0;
        if (rd && !wr && kind != 0 && !bad) begin
            case (kind)
                1: for (int i = 0; i < sz; i++)
                       e.data = e.data | (32'(model_mem[(a % Bytes) + i]) << (8 * i));
                2: e.data = {16'b0, model_gpio};
                3: e.data = model_cnt;
                default: e.data = {31'b0, model_err};
            endcase
        end
        e.err  = model_err;
        e.gpio = model_gpio;
        e.name = name;
        sb.push_back(e);
        @(posedge CLK);
        set = (rd && wr) || ((rd || wr) && kind != 0 && bad);
        clr = wr && kind == 4 && !bad && d[0];
        if (wr && !bad) begin
            if (kind == 1) begin
                for (int i = 0; i < sz; i++) model_mem[(a % Bytes) + i] = d[8*i +: 8];
            end else if (kind == 2) begin
                model_gpio = d[15:0];
            end
        end
        model_err = set ? 1'b1 : (clr ? 1'b0 : model_err);
        model_cnt = model_cnt + 1;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r <= 6)
            return $urandom_range(0, 3) * Bytes + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
        if (r == 7) return Base + $urandom_range(0, 3) * 4 + (($urandom_range(0, 3) == 0) ? 1 : 0);
        if (r == 8) return 32'h4000_0000 + $urandom_range(0, 15) * 4;
        return Base + 32'h100;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        int unsigned m;
        logic [2:0] valid_types [5];
        valid_types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        Reset = 1'b0;
        MEM_rd_en = 0; MEM_wr_en = 0; MEM_type = 3'd2; MEM_addr = 0; MEM_WR_out = 0;
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
        model_err = 0; model_gpio = 0; model_cnt = 0;
        #1;
        check("reset err", {31'b0, misalign_err}, 32'h0);
        check("reset gpio", {16'b0, gpio_out}, 32'h0);
        check("reset data", MEM_data, 32'h0);
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b1;

        for (int i = 0; i < 16; i++) cycle(0, 1, 3'd2, i * 4, 32'h0, "init");

        cycle(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, "sw_deadbeef");
        cycle(1, 0, 3'd2, 32'h10, 32'h0, "lw_deadbeef");
        cycle(0, 1, 3'd2, 32'h10, 32'h1122_3344, "sw_11223344");
        cycle(0, 1, 3'd0, 32'h13, 32'h0000_005A, "sb_5a");
        cycle(1, 0, 3'd2, 32'h10, 32'h0, "lw_merged");
        cycle(1, 0, 3'd4, 32'h13, 32'h0, "lbu_5a");
        cycle(1, 0, 3'd1, 32'h11, 32'h0, "lh_misaligned");
        cycle(1, 0, 3'd2, 32'h10, 32'h0, "err_sticky");
`ifdef DATA_MEM_MMIO_EN
        cycle(0, 1, 3'd2, Base + 8, 32'h1, "status_clear");
        cycle(1, 0, 3'd2, Base + 8, 32'h0, "status_read");
`endif
        cycle(1, 1, 3'd2, 32'h20, 32'hAAAA_5555, "rw_same_cycle");
        cycle(1, 0, 3'd2, 32'h20, 32'h0, "lw_after_rw");
        cycle(1, 0, 3'd2, 32'h4000_0000, 32'h0, "lw_unmapped");
`ifdef DATA_MEM_MMIO_EN
        cycle(0, 1, 3'd2, Base, 32'h1234_ABCD, "gpio_write");
        cycle(1, 0, 3'd2, Base + 4, 32'h0, "count_a");
        repeat (4) cycle(0, 0, 3'd2, 32'h0, 32'h0, "idle");
        cycle(1, 0, 3'd2, Base + 4, 32'h0, "count_b");
        cycle(0, 1, 3'd1, Base, 32'hFFFF_FFFF, "gpio_sh_bad");
`endif

        for (int n = 0; n < 400; n++) begin
            t = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(0, 7))
                                            : valid_types[$urandom_range(0, 4)];
            m = $urandom_range(0, 9);
            cycle(m <= 3 || m == 8, (m >= 4 && m <= 8), t, rand_addr(), $urandom(), "rand");
        end

        // Reset in the middle of a store cycle: word must keep its value.
        cycle(0, 1, 3'd2, 32'h30, 32'h0BAD_F00D, "sw_pre_reset");
        MEM_rd_en = 0; MEM_wr_en = 1; MEM_type = 3'd2; MEM_addr = 32'h30;
        MEM_WR_out = 32'h5555_AAAA;
        #2 Reset = 1'b0;
        #1;
        check("reset_mid err", {31'b0, misalign_err}, 32'h0);
        check("reset_mid gpio", {16'b0, gpio_out}, 32'h0);
        @(posedge CLK);
        #1;
        MEM_wr_en = 0;
`ifdef DATA_MEM_MMIO_EN
        MEM_rd_en = 1; MEM_addr = Base + 4;
        #1 check("reset_mid count", MEM_data, 32'h0);
        MEM_rd_en = 0;
`endif
        Reset = 1'b1;
        model_err = 0; model_gpio = 0; model_cnt = 0;
        cycle(1, 0, 3'd2, 32'h30, 32'h0, "lw_after_reset");
        cycle(1, 0, 3'd2, Base + 4, 32'h0, "count_after_reset");
        cycle(0, 0, 3'd2, 32'h0, 32'h0, "tail");

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two.
REQ-002 Parameter: MMIO_BASE, 32'h8000_0000, base address of the memory-mapped register block.
REQ-003 Port: CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port: Reset  in  1  asynchronous, active-low reset.
REQ-005 Port: MEM_addr  in  32  byte address from CPU execute stage.
REQ-006 Port: MEM_WR_out  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 Port: MEM_type  in  3  funct3 transfer size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 Port: MEM_rd_en  in  1  load request, same-cycle.
REQ-009 Port: MEM_wr_en  in  1  store request, committed at next CLK edge.
REQ-010 Port: MEM_data  out  32  load data, addressed bytes right-aligned, upper bits zero.
REQ-011 Port: misalign_err  out  1  sticky misaligned-access flag.
REQ-012 Port: gpio_out  out  16  GPIO output register.

Function
REQ-013 RAM region SHALL be addr[31:28]==0; word index addr[log2(DEPTH_WORDS)+1:2]; higher bits ignored (aliasing wrap).
REQ-014 Byte enables SHALL be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111.
REQ-015 Access SHALL be misaligned when H/HU with addr[0]=1, or W with addr[1:0]!=0; MEM_type 011/110/111 SHALL be treated as misaligned.
REQ-016 Aligned store SHALL write only enabled byte lanes, store data shifted left by 8*addr[1:0], at the next rising CLK.
REQ-017 Misaligned store SHALL write nothing; misalign_err SHALL set at the same edge.
REQ-018 Load SHALL be combinational, zero-latency: MEM_data valid in the cycle MEM_rd_en is high.
REQ-019 Misaligned load SHALL return MEM_data=0 and set misalign_err at next edge.
REQ-020 MEM_data SHALL be 0 whenever MEM_rd_en is low.
REQ-021 Load and store to the same word in the same cycle: load returns pre-edge contents.
REQ-022 MEM_rd_en and MEM_wr_en both high: store performed, MEM_data=0, misalign_err set.
REQ-023 Addresses outside RAM and MMIO regions: stores dropped, loads return 0, no error.
REQ-024 misalign_err SHALL remain set until reset or a clear per REQ-030.

Reset
REQ-025 Reset low SHALL immediately force misalign_err=0, gpio_out=0, cycle counter=0; MEM_data follows REQ-020.
REQ-026 RAM contents SHALL NOT be reset; a store coincident with Reset low SHALL be dropped.

Configuration
REQ-027 Macro DATA_MEM_MMIO_EN defined: MMIO block at MMIO_BASE implemented per REQ-028..030.
REQ-028 MMIO_BASE+0: GPIO, RW, lower 16 bits; word-only access, other sizes treated as misaligned.
REQ-029 MMIO_BASE+4: 32-bit free-running cycle counter, RO, increments every CLK, wraps FFFF_FFFF->0; writes ignored.
REQ-030 MMIO_BASE+8: status, bit0=misalign_err; word write with bit0=1 clears it; clear and new error in same cycle: set wins.
REQ-031 Macro undefined: no MMIO logic or counter; MMIO addresses behave per REQ-023; gpio_out tied 0.

Structure
REQ-032 Package dmem_pkg SHALL hold MEM_type encodings, region decode constants, MMIO offsets.
REQ-033 Sub-module dmem_lane_align SHALL compute byte enables, write-data shift, read-data extract, misalign detect.

Verification
REQ-034 SW 0xDEADBEEF @0x10; LW @0x10 -> MEM_data=0xDEADBEEF, misalign_err=0.
REQ-035 SB 0x5A @0x13 over 0x11223344; LW @0x10 -> 0x5A223344; LBU @0x13 -> 0x0000005A.
REQ-036 LH @0x11 -> MEM_data=0, misalign_err=1 next edge; SW 0x1 @MMIO_BASE+8 -> misalign_err=0.
REQ-037 Same-cycle SW 0xAAAA5555 and LW @0x20 (old 0x0) -> MEM_data=0x0; next-cycle LW -> 0xAAAA5555.
REQ-038 (MMIO_EN) SW 0x1234ABCD @MMIO_BASE -> gpio_out=0xABCD; two LW @MMIO_BASE+4 N cycles apart differ by N.
REQ-039 Assert Reset low mid-SW @0x30 -> word unchanged, gpio_out=0, counter=0, misalign_err=0 immediately.
